wb_bram_ctrl: RTL
=================

Name: wb_bram_ctrl

Overview:
- Parametrised Wishbone-slave SRAM controller for the user project area.
- Serves an internal multi-bank byte-writable memory with a runtime-programmable access delay.
- Adds a CSR window for the delay setting and access/error counters, plus an error response for unmapped addresses.
- Sits between the management-SoC Wishbone bus and user logic; successor of the fixed-delay single-BRAM responder.

Parameters:
- MEM_BASE, 32'h3800_0000, byte base address of memory window.
- CSR_BASE, 32'h3000_0000, byte base address of 4-word CSR window.
- ADDR_W, 10, word-address bits per bank (bank depth 2^ADDR_W words).
- NBANK, 2, number of banks (power of 2, >=1); bank = word address bits above ADDR_W.
- DELAYS, 10, reset value of the wait-cycle count (0..255).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1=write
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  normal termination, one-cycle pulse
- wbs_err_o  out  1  error termination, one-cycle pulse
- wbs_dat_o  out  32  read data, valid while wbs_ack_o=1
- busy_o  out  1  high when FSM not in IDLE
- err_irq_o  out  1  one-cycle pulse on every error termination

Behaviour:
- Reset: FSM=IDLE; ack/err/err_irq/busy=0; dat_o=0; delay CSR=DELAYS; all counters=0. Memory contents are not reset.
- Reset asserted mid-transaction aborts it: no ack, no memory write.
- Decode at accept:
  - MEM hit: MEM_BASE <= adr < MEM_BASE + NBANK*2^ADDR_W*4.
  - CSR hit: CSR_BASE <= adr < CSR_BASE + 16.
  - Anything else is a miss.
  - adr[1:0] is ignored.
- FSM states: IDLE, WAIT, ACCESS, RESP, ERR.
  - IDLE: on cyc&stb, latch adr/we/sel/dat and load the wait counter from the delay CSR.
    - Miss -> ERR.
    - CSR hit -> RESP.
    - MEM hit -> WAIT if delay>0, else ACCESS.
  - WAIT: counter decrements each cycle; at 1 -> ACCESS. If cyc drops -> IDLE, no side effect, no ack.
  - ACCESS (MEM only):
    - Write: bytes with sel=1 are written at the end of this cycle, ack=1 this cycle, -> IDLE.
    - Read: memory read issued; -> RESP.
  - RESP: ack=1, dat_o = registered read data (MEM) or CSR value; -> IDLE.
  - ERR: err=1, err_irq=1, dat_o=0; -> IDLE.
- Latency, counting cycles after the accept edge:
  - MEM write: ack in cycle D+1.
  - MEM read: ack in cycle D+2.
  - CSR read/write: ack in cycle 1.
  - Error: err in cycle 1.
  - D is the delay CSR value at accept.
- ack and err are never both high. Exactly one termination per accepted, non-aborted request.
- Back-to-back: a new request is sampled in the IDLE cycle after termination.
- CSR map (word offset):
  - 0 = delay[7:0], R/W. Write uses sel[0] only; the upper bits read 0.
  - 1 = read count[15:0]. Completed MEM reads.
  - 2 = write count[15:0]. Completed MEM writes.
  - 3 = error count[15:0].
  - Any write to words 1-3 clears that counter; the data value is ignored.
- Counters wrap 16'hFFFF -> 0. They increment in the termination cycle.
- A delay CSR write affects only later requests.
- Memory: NBANK*2^ADDR_W x 32 words. Write with sel=0 acks with no change. Read-after-write to the same address returns the new data.

Test Plan:
- Reset, write 32'hDEADBEEF to 0x3800_0004 with sel=4'hF, then read it back -> write ack 11 cycles after accept; read ack 12 cycles after accept with dat_o=32'hDEADBEEF.
- Write 32'h0000_0003 to CSR 0x3000_0000 (acked in cycle 1), then write sel=4'b0010 data 32'h0000_AB00 over 32'h11223344 at 0x3800_0010 -> write ack at cycle 4; read returns 32'h1122AB44 with ack at cycle 5.
- Set delay 0, write 32'hCAFEF00D at 0x3800_1000 (bank 1, word 0), then read 0x3800_0000 -> bank 1 holds 32'hCAFEF00D, bank 0 is unchanged; write ack at cycle 1, read ack at cycle 2.
- Access 0x3800_2000 (just past the end) -> err=1 and err_irq=1 at cycle 1, no ack; CSR word 3 reads 1.
- Drop cyc during WAIT on a write to 0x3800_0008 -> no ack/err; later read of 0x3800_0008 returns the old data; write count unchanged.
- Assert wb_rst_i during WAIT -> outputs 0 immediately; delay CSR reads back 10; counters read 0.

Source files
------------

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave SRAM controller: multi-bank byte-writable memory with a programmable
// access delay, a 4-word CSR window (delay plus access/error counters) and error replies.
module wb_bram_ctrl #(
  parameter logic [31:0] MEM_BASE = 32'h3800_0000,
  parameter logic [31:0] CSR_BASE = 32'h3000_0000,
  parameter int          ADDR_W   = 10,
  parameter int          NBANK    = 2,
  parameter int          DELAYS   = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o,
  output logic        err_irq_o
);

  localparam int          BANK_W    = $clog2(NBANK);
  localparam int          IDX_W     = ADDR_W + BANK_W;
  localparam int          DEPTH     = NBANK << ADDR_W;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'd4;

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RESP, ERR} state_t;

  state_t             state, state_nxt;
  logic [31:0]        adr_w, mem_off, csr_off, csr_val;
  logic               mem_hit, csr_hit, accept;
  logic               we_q, is_mem_q;
  logic [3:0]         sel_q;
  logic [31:0]        dat_q, csr_rd_q, mem_rd_q;
  logic [IDX_W-1:0]   idx_q;
  logic [1:0]         csr_idx_q;
  logic [7:0]         delay, wait_cnt;
  logic [15:0]        rd_cnt, wr_cnt, err_cnt;
  logic [31:0]        mem [DEPTH];

  assign adr_w   = wbs_adr_i & 32'hFFFF_FFFC;
  assign mem_off = adr_w - MEM_BASE;
  assign csr_off = adr_w - CSR_BASE;
  assign mem_hit = (adr_w >= MEM_BASE) && ({1'b0, mem_off} < MEM_BYTES);
  assign csr_hit = (adr_w >= CSR_BASE) && (csr_off < 32'd16);
  assign accept  = (state == IDLE) && wbs_cyc_i && wbs_stb_i;

  always_comb begin
    csr_val = 32'd0;
    case (csr_off[3:2])
      2'd0: csr_val = {24'd0, delay};
      2'd1: csr_val = {16'd0, rd_cnt};
      2'd2: csr_val = {16'd0, wr_cnt};
      2'd3: csr_val = {16'd0, err_cnt};
      default: csr_val = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Dropping cyc in WAIT takes priority over the final countdown step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_hit)      state_nxt = (delay != 8'd0) ? WAIT : ACCESS;
          else if (csr_hit) state_nxt = RESP;
          else              state_nxt = ERR;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i)             state_nxt = IDLE;
        else if (wait_cnt == 8'd1)  state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = we_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wbs_ack_o = (state == RESP) || ((state == ACCESS) && we_q);
  assign wbs_err_o = (state == ERR);
  assign err_irq_o = (state == ERR);
  assign busy_o    = (state != IDLE);
  assign wbs_dat_o = (state == RESP) ? (is_mem_q ? mem_rd_q : csr_rd_q) : 32'd0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      we_q      <= 1'b0;
      is_mem_q  <= 1'b0;
      sel_q     <= 4'd0;
      dat_q     <= 32'd0;
      idx_q     <= '0;
      csr_idx_q <= 2'd0;
      csr_rd_q  <= 32'd0;
      wait_cnt  <= 8'd0;
      delay     <= 8'(DELAYS);
      rd_cnt    <= 16'd0;
      wr_cnt    <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (accept) begin
        we_q      <= wbs_we_i;
        is_mem_q  <= mem_hit;
        sel_q     <= wbs_sel_i;
        dat_q     <= wbs_dat_i;
        idx_q     <= mem_off[IDX_W+1:2];
        csr_idx_q <= csr_off[3:2];
        csr_rd_q  <= csr_val;
        wait_cnt  <= delay;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if ((state == ACCESS) && we_q) wr_cnt  <= wr_cnt + 16'd1;
      if ((state == RESP) && is_mem_q) rd_cnt <= rd_cnt + 16'd1;
      if (state == ERR)                err_cnt <= err_cnt + 16'd1;
      // CSR writes land in the reply cycle, so they only affect later requests.
      if ((state == RESP) && !is_mem_q && we_q) begin
        case (csr_idx_q)
          2'd0: if (sel_q[0]) delay <= dat_q[7:0];
          2'd1: rd_cnt  <= 16'd0;
          2'd2: wr_cnt  <= 16'd0;
          2'd3: err_cnt <= 16'd0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && (state == ACCESS)) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_q[b]) mem[idx_q][b*8 +: 8] <= dat_q[b*8 +: 8];
        end
      end else begin
        mem_rd_q <= mem[idx_q];
      end
    end
  end

endmodule
